mem_write_buf: RTL and testbench

Posted-write buffer and write-strobe generator between the processor datapath and data memory. Processor write requests with address and data are queued in a DEPTH-entry FIFO. Each request is replayed to memory as a registered write-enable pulse of HOLD_CYCLES cycles, followed by at least one idle cycle. It is the parametrised successor of the single-bit registered write-enable, adding width, buffering, a fixed strobe length and optional memory wait states.

---
 rtl/mem_write_buf.sv | 118 +++++++++++
 tb/tb_mem_write_buf.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_write_buf.sv
// rtl/mem_write_buf.sv - posted-write FIFO replaying requests as fixed-length memory write strobes
// Optional memory wait states: MEMW_WAIT_EN
module mem_write_buf #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         write,
    input  logic [ADDR_WIDTH-1:0]        addr_in,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         mem_we,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_data
`ifdef MEMW_WAIT_EN
    ,
    input  logic                         mem_ready
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_STROBE  = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;

    logic [EW-1:0] fifo_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [HW-1:0] hold;
    logic          push;
    logic          pop;
    logic          mem_go;

`ifdef MEMW_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    // A full FIFO refuses a write even when the same edge frees an entry.
    assign push = write && (count != CW'(DEPTH));
    assign pop  = ((state == S_IDLE) || (state == S_RECOVER)) && (count != '0);

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0) && (state != S_STROBE);
    assign pending = count;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[tail] <= {addr_in, data_in};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            hold     <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            case (state)
                S_IDLE, S_RECOVER: begin
                    if (pop) begin
                        mem_we                 <= 1'b1;
                        {mem_addr, mem_data}   <= fifo_mem[head];
                        hold                   <= HW'(HOLD_CYCLES - 1);
                        state                  <= S_STROBE;
                    end else begin
                        mem_we <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_STROBE: begin
                    // Wait states only stretch the strobe once its fixed length has elapsed.
                    if (hold != '0) begin
                        hold <= hold - HW'(1);
                    end else if (mem_go) begin
                        mem_we <= 1'b0;
                        state  <= S_RECOVER;
                    end
                end
                default: begin
                    mem_we <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_buf.sv
// tb/tb_mem_write_buf.sv - bench for mem_write_buf, HOLD_CYCLES 1 and 3 side by side against a timeline model
module tb_mem_write_buf;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic        write;
    logic [7:0]  addr_in;
    logic [15:0] data_in;
    logic        ready;

    logic        we_o    [2];
    logic        full_o  [2];
    logic        empty_o [2];
    logic [2:0]  pend_o  [2];
    logic [7:0]  ma_o    [2];
    logic [15:0] md_o    [2];

    always #5 clock = ~clock;

    mem_write_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .HOLD_CYCLES(1)) u_h1 (
        .clock(clock), .resetn(resetn), .write(write), .addr_in(addr_in), .data_in(data_in),
        .full(full_o[0]), .empty(empty_o[0]), .pending(pend_o[0]),
        .mem_we(we_o[0]), .mem_addr(ma_o[0]), .mem_data(md_o[0])
`ifdef MEMW_WAIT_EN
        , .mem_ready(ready)
`endif
    );

    mem_write_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .HOLD_CYCLES(3)) u_h3 (
        .clock(clock), .resetn(resetn), .write(write), .addr_in(addr_in), .data_in(data_in),
        .full(full_o[1]), .empty(empty_o[1]), .pending(pend_o[1]),
        .mem_we(we_o[1]), .mem_addr(ma_o[1]), .mem_data(md_o[1])
`ifdef MEMW_WAIT_EN
        , .mem_ready(ready)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // Model: queue of accepted requests plus the edge the current strobe started on.
    logic [23:0] qd [2][1024];
    int          qh [2];
    int          qt [2];
    bit          busy [2];
    int          next_free [2];
    int          start_e [2];
    logic [7:0]  exp_addr [2];
    logic [15:0] exp_data [2];

    function automatic int hold_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s hold=%0d observed=%0h expected=%0h", tag, hold_of(i), obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            qh[i] = 0; qt[i] = 0; busy[i] = 1'b0; next_free[i] = 0; start_e[i] = 0;
            exp_addr[i] = '0; exp_data[i] = '0;
        end
    endtask

    task automatic model_step(input int i);
        int cnt;
        cnt = qt[i] - qh[i];
        if (busy[i] && (edge_n >= start_e[i] + hold_of(i)) && ready) begin
            busy[i]      = 1'b0;
            next_free[i] = edge_n + 1;
        end
        if (!busy[i] && (edge_n >= next_free[i]) && (cnt > 0)) begin
            {exp_addr[i], exp_data[i]} = qd[i][qh[i]];
            qh[i]++;
            busy[i]    = 1'b1;
            start_e[i] = edge_n;
        end
        if (write && (cnt < DEPTH)) begin
            qd[i][qt[i]] = {addr_in, data_in};
            qt[i]++;
        end
    endtask

    task automatic check_all();
        int n;
        for (int i = 0; i < 2; i++) begin
            n = qt[i] - qh[i];
            chk("mem_we",   i, 32'(we_o[i]),    32'(busy[i]));
            chk("mem_addr", i, 32'(ma_o[i]),    32'(exp_addr[i]));
            chk("mem_data", i, 32'(md_o[i]),    32'(exp_data[i]));
            chk("pending",  i, 32'(pend_o[i]),  32'(n));
            chk("full",     i, 32'(full_o[i]),  32'(n == DEPTH));
            chk("empty",    i, 32'(empty_o[i]), 32'((n == 0) && !busy[i]));
        end
    endtask

    task automatic cycle(input bit w, input logic [7:0] a, input logic [15:0] d, input bit r);
        write = w; addr_in = a; data_in = d; ready = r;
        for (int i = 0; i < 2; i++) model_step(i);
        edge_n++;
        @(posedge clock);
        @(negedge clock);
        check_all();
    endtask

    task automatic mid_reset();
        write = 1'b0;
        #2 resetn = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_we",      i, 32'(we_o[i]),    32'd0);
            chk("rst_pending", i, 32'(pend_o[i]),  32'd0);
            chk("rst_empty",   i, 32'(empty_o[i]), 32'd1);
            chk("rst_full",    i, 32'(full_o[i]),  32'd0);
        end
        @(negedge clock);
        edge_n++;
        resetn = 1'b1;
        check_all();
    endtask

    initial begin
        resetn = 1'b0; write = 1'b0; addr_in = '0; data_in = '0; ready = 1'b1;
        model_reset();
        @(negedge clock);
        check_all();
        resetn = 1'b1;
        cycle(0, 8'h00, 16'h0000, 1);

        // Single write into an idle buffer
        cycle(1, 8'h12, 16'hBEEF, 1);
        chk("single_we_e0", 0, 32'(we_o[0]), 32'd0);
        cycle(0, 8'h00, 16'h0000, 1);
        chk("single_we_e1", 0, 32'(we_o[0]), 32'd1);
        chk("single_addr",  0, 32'(ma_o[0]), 32'h12);
        chk("single_data",  0, 32'(md_o[0]), 32'hBEEF);
        cycle(0, 8'h00, 16'h0000, 1);
        chk("single_we_e2", 0, 32'(we_o[0]),    32'd0);
        chk("single_empty", 0, 32'(empty_o[0]), 32'd1);
        for (int k = 0; k < 8; k++) cycle(0, 8'h00, 16'h0000, 1);

        // Burst overfilling the HOLD_CYCLES=3 buffer, including a write on a full+pop edge
        for (int k = 1; k <= 7; k++) begin
            cycle(1, 8'(k), 16'(k * 16'h0111), 1);
            if (k == 5) chk("burst_full", 1, 32'(full_o[1]), 32'd1);
            if (k == 6) chk("pop_full_drop_pending", 1, 32'(pend_o[1]), 32'd3);
        end
        for (int k = 0; k < 30; k++) cycle(0, 8'h00, 16'h0000, 1);

        // Reset with traffic queued and a strobe in progress
        for (int k = 0; k < 3; k++) cycle(1, 8'(8'h40 + k), 16'($urandom), 1);
        mid_reset();
        for (int k = 0; k < 3; k++) cycle(0, 8'h00, 16'h0000, 1);

`ifdef MEMW_WAIT_EN
        // Memory holds off a HOLD_CYCLES=1 strobe for four cycles
        cycle(1, 8'hA5, 16'h1234, 1);
        cycle(0, 8'h00, 16'h0000, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 8'h00, 16'h0000, 0);
            chk("wait_we",   0, 32'(we_o[0]), 32'd1);
            chk("wait_addr", 0, 32'(ma_o[0]), 32'hA5);
        end
        cycle(0, 8'h00, 16'h0000, 1);
        chk("wait_release", 0, 32'(we_o[0]), 32'd0);
        for (int k = 0; k < 30; k++) cycle(0, 8'h00, 16'h0000, 1);
`endif

        // Randomised traffic, long enough to wrap the pointers many times
        for (int k = 0; k < 400; k++) begin
`ifdef MEMW_WAIT_EN
            cycle($urandom_range(0, 99) < 60, 8'($urandom), 16'($urandom), $urandom_range(0, 3) != 0);
`else
            cycle($urandom_range(0, 99) < 60, 8'($urandom), 16'($urandom), 1);
`endif
        end
        for (int k = 0; k < 40; k++) cycle(0, 8'h00, 16'h0000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
